uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Parametrised UART receive engine: start detect, 3-sample majority bit recovery, LSB-first deserialisation,
//  even/odd parity check, 1 or 2 stop bits, line-break detection. Sits behind the RX_IN synchroniser and
//  feeds the system-control block with a data word plus per-frame status. One clock domain (UART clock).
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame, legal 5..9
//  PRESC_W     6  width of PRESCALE port; max oversampling ratio 2**PRESC_W-2
// PORTS
//  CLK         in   1           UART clock; all flops on rising edge
//  RST         in   1           reset, synchronous, active-high
//  RX_IN       in   1           serial line, already synchronised; idle level 1
//  PRESCALE    in   PRESC_W     oversampling ratio, even, >=8
//  PAR_EN      in   1           1 = parity bit present
//  PAR_TYP     in   1           0 = even, 1 = odd
//  STOP2       in   1           1 = two stop bits
//  P_DATA      out  DATA_WIDTH  received word, held until next FRAME_DONE
//  FRAME_DONE  out  1           1-cycle pulse per completed frame (good or bad)
//  DATA_VALID  out  1           1-cycle pulse, = FRAME_DONE & ~PAR_ERR & ~STOP_ERR & ~BREAK_DET
//  PAR_ERR     out  1           parity error of last frame, updated on FRAME_DONE
//  STOP_ERR    out  1           any stop bit sampled 0, updated on FRAME_DONE
//  BREAK_DET   out  1           1-cycle pulse: break frame detected
//  BUSY        out  1           1 whenever FSM not in IDLE
// BEHAVIOUR
//  - Reset (RST=1 at rising edge): FSM->IDLE, counters 0; P_DATA=0, all flags/pulses 0. Mid-frame reset drops frame, no pulses.
//  - Config latch: PRESCALE/PAR_EN/PAR_TYP/STOP2 registered on IDLE->START; changes mid-frame ignored.
//    PRESCALE<8 treated as 8; odd value uses M = PRESCALE>>1.
//  - Edge counter E: 0..P-1 per bit (P = latched PRESCALE), wraps to 0 and increments bit counter B.
//  - Sampling: RX_IN captured at E = M-1, M, M+1 (M = P/2); majority vote V registered, valid at E = M+2.
//  - States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
//    IDLE: RX_IN=0 -> START, E=0 (the cycle RX_IN is seen low counts as E=0).
//    START: at E=M+2 if V=1 -> IDLE next cycle (glitch, no outputs); at E=P-1 -> DATA, B=0.
//    DATA: at E=M+2 shift V into P_DATA shadow reg LSB-first; at E=P-1 with B=DATA_WIDTH-1 -> PARITY if PAR_EN else STOP.
//    PARITY: at E=M+2 PAR_ERR_n = V ^ (^data) ^ PAR_TYP; at E=P-1 -> STOP.
//    STOP: at E=M+2 accumulate STOP_ERR_n |= ~V; at E=P-1 of last stop bit (1 or 2) finish frame.
//  - Finish: next cycle FRAME_DONE=1, P_DATA/PAR_ERR/STOP_ERR updated, DATA_VALID per formula; FSM -> IDLE.
//    Break: data all 0, parity bit 0 (if enabled), first stop V=0 -> BREAK_DET pulse with FRAME_DONE,
//    DATA_VALID=0, FSM -> BRK_WAIT; BRK_WAIT -> IDLE on first cycle RX_IN=1 (no retrigger while line low).
//  - Back-to-back frames: RX_IN=0 in the cycle after finish starts next frame; no dead cycles required beyond that.
//  - PAR_ERR forced 0 when PAR_EN=0. Frame latency: start-edge to FRAME_DONE = P*(1+DATA_WIDTH+PAR_EN+1+STOP2)+1 cycles.
//  - Outputs all registered; no combinational path RX_IN -> outputs.
// STRUCTURE
//  - uart_pkg: state encoding localparams, PAR_EVEN/PAR_ODD constants, minimum-prescale constant (8).
//  - One sub-module uart_rx_sampler: edge counter, 3-sample capture, majority vote; outputs E, V, bit_tick.
//  - Top holds FSM, bit counter, shift register, parity/stop/break logic, output registers.
// TESTING
//  - P=8, 8N1, byte 0xA5 -> FRAME_DONE+DATA_VALID 1 cycle, P_DATA=0xA5, errors 0, latency 81 cycles.
//  - P=16, PAR_EN=1 PAR_TYP=0, 0x3C with wrong parity bit -> FRAME_DONE=1, PAR_ERR=1, DATA_VALID=0.
//  - P=32, RX_IN low 10 cycles then high -> return IDLE at E=18, no FRAME_DONE, BUSY falls.
//  - P=8, STOP2=1, second stop bit 0 -> STOP_ERR=1, DATA_VALID=0; next frame 0x55 clean clears STOP_ERR.
//  - Line held low 200 cycles (P=8, 8N1) -> one BREAK_DET pulse, no second frame until RX_IN=1.
//  - Assert RST mid-DATA of 0xFF -> all outputs 0 next cycle; following frame 0x12 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity sense,
// minimum oversampling ratio and the 3-sample majority helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_START    = ST_START,
        S_DATA     = ST_DATA,
        S_PARITY   = ST_PARITY,
        S_STOP     = ST_STOP,
        S_BRK_WAIT = ST_BRK_WAIT
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_PRESCALE = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority recovery around the bit centre.
// The vote is registered, so it is usable one edge after the last sample.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               run,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] presc,
    output logic [PRESC_W-1:0] e_cnt,
    output logic               vote,
    output logic               bit_tick
);

    localparam logic [PRESC_W-1:0] ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] mid;
    logic               s0;
    logic               s1;

    assign mid      = {1'b0, presc[PRESC_W-1:1]};
    assign bit_tick = run & (e_cnt == (presc - ONE));

    // Edge counter plus sample capture; the detecting cycle is E=0, so count resumes at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_cnt <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
            vote  <= 1'b0;
        end else begin
            if (start) begin
                e_cnt <= ONE;
            end else if (bit_tick) begin
                e_cnt <= '0;
            end else if (run) begin
                e_cnt <= e_cnt + ONE;
            end else begin
                e_cnt <= '0;
            end
            if (run && (e_cnt == (mid - ONE))) begin
                s0 <= rx_in;
            end
            if (run && (e_cnt == mid)) begin
                s1 <= rx_in;
            end
            if (run && (e_cnt == (mid + ONE))) begin
                vote <= maj3(s0, s1, rx_in);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive engine: frame FSM, deserialiser, parity/stop/break checks and
// registered per-frame status towards the system-control block.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  FRAME_DONE,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STOP_ERR,
    output logic                  BREAK_DET,
    output logic                  BUSY
);

    localparam int                 BW       = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]      BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]      LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESC_W-1:0] MIN_P    = PRESC_W'(MIN_PRESCALE);
    localparam logic [PRESC_W-1:0] TWO      = {{(PRESC_W-2){1'b0}}, 2'b10};

    rx_state_t             state;
    logic [PRESC_W-1:0]    p_lat;
    logic                  pe_lat;
    logic                  pt_lat;
    logic                  s2_lat;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_err_n;
    logic                  stop_err_n;
    logic                  par_bit;
    logic                  stop1_v;

    logic [PRESC_W-1:0]    e_cnt;
    logic                  vote;
    logic                  bit_tick;
    logic                  start_s;
    logic                  run_s;
    logic                  vote_tick_s;
    logic                  brk_s;
    logic                  par_fail_s;

    assign start_s     = (state == S_IDLE) & ~RX_IN;
    assign run_s       = (state == S_START) | (state == S_DATA) | (state == S_PARITY) | (state == S_STOP);
    assign vote_tick_s = run_s & (e_cnt == ({1'b0, p_lat[PRESC_W-1:1]} + TWO));
    assign brk_s       = (shift == '0) & (~pe_lat | ~par_bit) & ~stop1_v;
    assign par_fail_s  = pe_lat & par_err_n;

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk      (CLK),
        .rst      (RST),
        .start    (start_s),
        .run      (run_s),
        .rx_in    (RX_IN),
        .presc    (p_lat),
        .e_cnt    (e_cnt),
        .vote     (vote),
        .bit_tick (bit_tick)
    );

    // Frame FSM with registered status; pulses default low every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            p_lat      <= MIN_P;
            pe_lat     <= 1'b0;
            pt_lat     <= 1'b0;
            s2_lat     <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_err_n  <= 1'b0;
            stop_err_n <= 1'b0;
            par_bit    <= 1'b0;
            stop1_v    <= 1'b0;
            P_DATA     <= '0;
            FRAME_DONE <= 1'b0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STOP_ERR   <= 1'b0;
            BREAK_DET  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            DATA_VALID <= 1'b0;
            BREAK_DET  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!RX_IN) begin
                        state      <= S_START;
                        BUSY       <= 1'b1;
                        p_lat      <= (PRESCALE < MIN_P) ? MIN_P : PRESCALE;
                        pe_lat     <= PAR_EN;
                        pt_lat     <= PAR_TYP;
                        s2_lat     <= STOP2;
                        bit_cnt    <= '0;
                        par_err_n  <= 1'b0;
                        stop_err_n <= 1'b0;
                        par_bit    <= 1'b0;
                    end
                end
                S_START: begin
                    if (vote_tick_s && vote) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end else if (bit_tick) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (vote_tick_s) begin
                        shift <= {vote, shift[DATA_WIDTH-1:1]};
                    end
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state   <= pe_lat ? S_PARITY : S_STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end
                S_PARITY: begin
                    if (vote_tick_s) begin
                        par_err_n <= vote ^ (^shift) ^ (pt_lat == PAR_ODD);
                        par_bit   <= vote;
                    end
                    if (bit_tick) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (vote_tick_s) begin
                        stop_err_n <= stop_err_n | ~vote;
                        if (bit_cnt == '0) begin
                            stop1_v <= vote;
                        end
                    end
                    if (bit_tick) begin
                        if (s2_lat && (bit_cnt == '0)) begin
                            bit_cnt <= BIT_ONE;
                        end else begin
                            FRAME_DONE <= 1'b1;
                            P_DATA     <= shift;
                            PAR_ERR    <= par_fail_s;
                            STOP_ERR   <= stop_err_n;
                            BREAK_DET  <= brk_s;
                            DATA_VALID <= ~par_fail_s & ~stop_err_n & ~brk_s;
                            state      <= brk_s ? S_BRK_WAIT : S_IDLE;
                            BUSY       <= brk_s;
                        end
                    end
                end
                S_BRK_WAIT: begin
                    if (RX_IN) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: a bit-level line driver pushes the
// expected frame outcome, a negedge monitor pops it whenever FRAME_DONE fires.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic [7:0] P_DATA;
    logic       FRAME_DONE;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STOP_ERR;
    logic       BREAK_DET;
    logic       BUSY;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .FRAME_DONE (FRAME_DONE),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STOP_ERR   (STOP_ERR),
        .BREAK_DET  (BREAK_DET),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        bit          par_err;
        bit          stop_err;
        bit          brk;
        int unsigned lat;
        int unsigned t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t brk_e;
    int   total = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every FRAME_DONE must match the oldest outstanding frame.
    always @(negedge CLK) begin
        if (FRAME_DONE) begin
            if (exp_q.size() == 0) begin
                total++;
                fails++;
                $display("FAIL unexpected_frame: FRAME_DONE with P_DATA=0x%0h, none expected", P_DATA);
            end else begin
                mon_e = exp_q.pop_front();
                check("p_data", {24'd0, P_DATA}, {24'd0, mon_e.data});
                check("par_err", {31'd0, PAR_ERR}, {31'd0, mon_e.par_err});
                check("stop_err", {31'd0, STOP_ERR}, {31'd0, mon_e.stop_err});
                check("break_det", {31'd0, BREAK_DET}, {31'd0, mon_e.brk});
                check("data_valid", {31'd0, DATA_VALID},
                      {31'd0, !(mon_e.par_err || mon_e.stop_err || mon_e.brk)});
                check("latency", cyc - mon_e.t0 + 1, mon_e.lat);
            end
        end else if (DATA_VALID || BREAK_DET) begin
            total++;
            fails++;
            $display("FAIL stray_pulse: DATA_VALID=%0b BREAK_DET=%0b without FRAME_DONE", DATA_VALID, BREAK_DET);
        end
    end

    // Drives one frame bit by bit and records what the receiver should report.
    task automatic send_frame(input logic [7:0] d, input int pin, input bit pe, input bit pt, input bit s2,
                              input bit flip, input bit st1, input bit st2, input int gap_in);
        int   p;
        int   ones;
        int   gap;
        logic pb;
        logic bits[$];
        exp_t e;
        p    = (pin < 8) ? 8 : pin;
        ones = $countones(d);
        pb   = ((ones % 2) == 1) ^ pt ^ flip;
        e.data     = d;
        e.par_err  = pe && (((ones + int'(pb)) % 2) != int'(pt));
        e.stop_err = !st1 || (s2 && !st2);
        e.brk      = (d == 8'd0) && (!pe || !pb) && !st1;
        e.lat      = p * (10 + int'(pe) + int'(s2)) + 1;
        gap = gap_in;
        if ((e.brk || !(s2 ? st2 : st1)) && gap < 1) gap = 1;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pb);
        bits.push_back(st1);
        if (s2) bits.push_back(st2);
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge CLK);
                if (k == 0 && c == 0) begin
                    PRESCALE = 6'(pin);
                    PAR_EN   = pe;
                    PAR_TYP  = pt;
                    STOP2    = s2;
                    e.t0     = cyc;
                    exp_q.push_back(e);
                end else if (k == 0 && c == 1) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    STOP2    = 1'($urandom);
                end
                RX_IN = bits[k];
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_outputs", {18'd0, P_DATA, FRAME_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BREAK_DET, BUSY}, 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2);

        // Short low pulse: start bit rejected at the vote edge.
        @(negedge CLK);
        PRESCALE = 6'd32;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        RX_IN    = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            if (k == 10) RX_IN = 1'b1;
            if (k == 18) check("glitch_busy_at_e18", {31'd0, BUSY}, 32'd1);
            if (k == 19) check("glitch_back_idle", {31'd0, BUSY}, 32'd0);
        end
        repeat (40) @(negedge CLK);

        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8'hC3, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8'h0F, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);

        // Line held low for 200 cycles: one break frame, then wait for idle.
        @(negedge CLK);
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        RX_IN    = 1'b0;
        brk_e.data = 8'd0;
        brk_e.par_err = 1'b0;
        brk_e.stop_err = 1'b1;
        brk_e.brk = 1'b1;
        brk_e.lat = 81;
        brk_e.t0 = cyc;
        exp_q.push_back(brk_e);
        repeat (199) @(negedge CLK);
        check("break_wait_busy", {31'd0, BUSY}, 32'd1);
        RX_IN = 1'b1;
        @(negedge CLK);
        check("break_release_idle", {31'd0, BUSY}, 32'd0);
        repeat (4) @(negedge CLK);

        // Reset in the middle of the data bits of an all-ones frame.
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midframe_reset_outputs", {18'd0, P_DATA, FRAME_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BREAK_DET, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);

        for (int n = 0; n < 24; n++) begin
            int         p;
            logic [7:0] d;
            p = 2 * int'($urandom_range(10, 4));
            if ($urandom_range(7, 0) == 0) p = 4;
            d = 8'($urandom);
            if ($urandom_range(7, 0) == 0) d = 8'd0;
            send_frame(d, p, 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(4, 0) == 0), ($urandom_range(5, 0) != 0),
                       ($urandom_range(5, 0) != 0), int'($urandom_range(2, 0)));
        end

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            total++;
            fails++;
            $display("FAIL drain_timeout: %0d frames still outstanding, expected 0", exp_q.size());
        end
        repeat (5) @(negedge CLK);
        check("final_idle", {31'd0, BUSY}, 32'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
